// File: rtl/decode_unit.sv
// RV32I OP/OP-IMM decode stage with a 32x32 register file, write-through bypass,
// a single-entry valid/ready output register and a free-running issue counter.
module decode_unit (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        instr_valid_in,
  input  logic [31:0] instr_in,
  output logic        instr_ready_out,
  input  logic        wb_en_in,
  input  logic [4:0]  wb_rd_in,
  input  logic [31:0] wb_data_in,
  output logic        dec_valid_out,
  input  logic        alu_ready_in,
  output logic [6:0]  opcode_out,
  output logic [2:0]  funct3_out,
  output logic [6:0]  funct7_out,
  output logic [4:0]  rd_out,
  output logic [31:0] rs1_value_out,
  output logic [31:0] mux_result_out,
  output logic        illegal_out,
  output logic [15:0] issue_count_out
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  logic [31:0] regs_q [32];

  logic        dec_valid_q, dec_valid_d;
  logic [6:0]  opcode_q, opcode_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [6:0]  funct7_q, funct7_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] rs1_value_q, rs1_value_d;
  logic [31:0] mux_result_q, mux_result_d;
  logic        illegal_q, illegal_d;
  logic [15:0] issue_count_q, issue_count_d;

  logic        ready;
  logic        accept;
  logic [4:0]  rs1_idx, rs2_idx;
  logic [31:0] rs1_val, rs2_val;
  logic [6:0]  opc, f7_raw;
  logic [2:0]  f3;
  logic        shift_f3;

  // A read returns the write-back value when it targets the same nonzero register
  function automatic logic [31:0] read_reg(
    input logic [4:0]  idx,
    input logic [31:0] stored,
    input logic        we,
    input logic [4:0]  wrd,
    input logic [31:0] wdata
  );
    logic [31:0] val;
    if (idx == 5'd0) begin
      val = 32'd0;
    end else if (we && (wrd == idx)) begin
      val = wdata;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  assign ready   = !rst_in && (!dec_valid_q || alu_ready_in);
  assign accept  = instr_valid_in && ready;
  assign rs1_idx = instr_in[19:15];
  assign rs2_idx = instr_in[24:20];
  assign opc     = instr_in[6:0];
  assign f3      = instr_in[14:12];
  assign f7_raw  = instr_in[31:25];
  assign shift_f3 = (f3 == 3'b001) || (f3 == 3'b101);
  assign rs1_val = read_reg(rs1_idx, regs_q[rs1_idx], wb_en_in, wb_rd_in, wb_data_in);
  assign rs2_val = read_reg(rs2_idx, regs_q[rs2_idx], wb_en_in, wb_rd_in, wb_data_in);

  always_comb begin
    dec_valid_d   = dec_valid_q;
    opcode_d      = opcode_q;
    funct3_d      = funct3_q;
    funct7_d      = funct7_q;
    rd_d          = rd_q;
    rs1_value_d   = rs1_value_q;
    mux_result_d  = mux_result_q;
    illegal_d     = illegal_q;
    issue_count_d = issue_count_q;
    if (accept) begin
      dec_valid_d   = 1'b1;
      issue_count_d = issue_count_q + 16'd1;
      opcode_d      = opc;
      funct3_d      = f3;
      rd_d          = instr_in[11:7];
      // Unsupported forms of OP/OP-IMM still carry their operands; only foreign opcodes zero them
      if (opc == OPC_OP) begin
        rs1_value_d  = rs1_val;
        mux_result_d = rs2_val;
        funct7_d     = f7_raw;
        illegal_d    = !((f7_raw == F7_ZERO) ||
                         ((f7_raw == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))));
      end else if (opc == OPC_OP_IMM) begin
        rs1_value_d  = rs1_val;
        mux_result_d = {{20{instr_in[31]}}, instr_in[31:20]};
        funct7_d     = shift_f3 ? f7_raw : 7'd0;
        illegal_d    = ((f3 == 3'b001) && (f7_raw != F7_ZERO)) ||
                       ((f3 == 3'b101) && (f7_raw != F7_ZERO) && (f7_raw != F7_ALT));
      end else begin
        rs1_value_d  = 32'd0;
        mux_result_d = 32'd0;
        funct7_d     = 7'd0;
        illegal_d    = 1'b1;
      end
    end else if (alu_ready_in) begin
      dec_valid_d = 1'b0;
    end else begin
      dec_valid_d = dec_valid_q;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      dec_valid_q   <= 1'b0;
      opcode_q      <= 7'd0;
      funct3_q      <= 3'd0;
      funct7_q      <= 7'd0;
      rd_q          <= 5'd0;
      rs1_value_q   <= 32'd0;
      mux_result_q  <= 32'd0;
      illegal_q     <= 1'b0;
      issue_count_q <= 16'd0;
    end else begin
      dec_valid_q   <= dec_valid_d;
      opcode_q      <= opcode_d;
      funct3_q      <= funct3_d;
      funct7_q      <= funct7_d;
      rd_q          <= rd_d;
      rs1_value_q   <= rs1_value_d;
      mux_result_q  <= mux_result_d;
      illegal_q     <= illegal_d;
      issue_count_q <= issue_count_d;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
    end else if (wb_en_in && (wb_rd_in != 5'd0)) begin
      regs_q[wb_rd_in] <= wb_data_in;
    end
  end

  assign instr_ready_out = ready;
  assign dec_valid_out   = dec_valid_q;
  assign opcode_out      = opcode_q;
  assign funct3_out      = funct3_q;
  assign funct7_out      = funct7_q;
  assign rd_out          = rd_q;
  assign rs1_value_out   = rs1_value_q;
  assign mux_result_out  = mux_result_q;
  assign illegal_out     = illegal_q;
  assign issue_count_out = issue_count_q;

endmodule

// File: tb/tb_decode_unit.sv
// Self-checking bench for decode_unit: directed scenarios plus random traffic
// against a behavioural model of the decode rules and register file.
module tb_decode_unit;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        instr_valid_in;
  logic [31:0] instr_in;
  logic        instr_ready_out;
  logic        wb_en_in;
  logic [4:0]  wb_rd_in;
  logic [31:0] wb_data_in;
  logic        dec_valid_out;
  logic        alu_ready_in;
  logic [6:0]  opcode_out;
  logic [2:0]  funct3_out;
  logic [6:0]  funct7_out;
  logic [4:0]  rd_out;
  logic [31:0] rs1_value_out;
  logic [31:0] mux_result_out;
  logic        illegal_out;
  logic [15:0] issue_count_out;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  logic [31:0] m_regs [32];
  logic        m_valid;
  logic [6:0]  m_op, m_f7;
  logic [2:0]  m_f3;
  logic [4:0]  m_rd;
  logic [31:0] m_rs1, m_mux;
  logic        m_ill;
  logic [15:0] m_cnt;

  decode_unit dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .instr_valid_in(instr_valid_in), .instr_in(instr_in), .instr_ready_out(instr_ready_out),
    .wb_en_in(wb_en_in), .wb_rd_in(wb_rd_in), .wb_data_in(wb_data_in),
    .dec_valid_out(dec_valid_out), .alu_ready_in(alu_ready_in),
    .opcode_out(opcode_out), .funct3_out(funct3_out), .funct7_out(funct7_out), .rd_out(rd_out),
    .rs1_value_out(rs1_value_out), .mux_result_out(mux_result_out),
    .illegal_out(illegal_out), .issue_count_out(issue_count_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_valid = 1'b0; m_op = 7'd0; m_f3 = 3'd0; m_f7 = 7'd0; m_rd = 5'd0;
    m_rs1 = 32'd0; m_mux = 32'd0; m_ill = 1'b0; m_cnt = 16'd0;
  endtask

  function automatic logic [31:0] model_read(input int idx, input logic we, input int wrd,
                                             input logic [31:0] wd);
    if (idx == 0) return 32'd0;
    if (we && wrd == idx) return wd;
    return m_regs[idx];
  endfunction

  // Apply the RV32I OP/OP-IMM rules to one accepted word
  task automatic model_accept(input logic [31:0] ins, input logic we, input int wrd,
                              input logic [31:0] wd);
    int op, f3, f7, imm;
    op  = int'(ins[6:0]);
    f3  = int'(ins[14:12]);
    f7  = int'(ins[31:25]);
    imm = int'($signed(ins[31:20]));
    m_valid = 1'b1;
    m_cnt   = m_cnt + 16'd1;
    m_op = ins[6:0]; m_f3 = ins[14:12]; m_rd = ins[11:7];
    if (op == 'h33) begin
      m_rs1 = model_read(int'(ins[19:15]), we, wrd, wd);
      m_mux = model_read(int'(ins[24:20]), we, wrd, wd);
      m_f7  = ins[31:25];
      m_ill = !(f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)));
    end else if (op == 'h13) begin
      m_rs1 = model_read(int'(ins[19:15]), we, wrd, wd);
      m_mux = imm;
      m_f7  = (f3 == 1 || f3 == 5) ? ins[31:25] : 7'd0;
      m_ill = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 32);
    end else begin
      m_rs1 = 32'd0; m_mux = 32'd0; m_f7 = 7'd0; m_ill = 1'b1;
    end
  endtask

  task automatic cycle(input logic v, input logic [31:0] ins, input logic ar,
                       input logic we, input logic [4:0] wrd, input logic [31:0] wd);
    logic exp_ready;
    @(negedge clk_in);
    instr_valid_in = v; instr_in = ins; alu_ready_in = ar;
    wb_en_in = we; wb_rd_in = wrd; wb_data_in = wd;
    #1;
    exp_ready = !m_valid || ar;
    check_val("ready", {31'd0, instr_ready_out}, {31'd0, exp_ready});
    @(posedge clk_in);
    if (v && exp_ready) model_accept(ins, we, int'(wrd), wd);
    else if (ar) m_valid = 1'b0;
    if (we && wrd != 5'd0) m_regs[wrd] = wd;
    #1;
    check_val("valid", {31'd0, dec_valid_out}, {31'd0, m_valid});
    check_val("count", {16'd0, issue_count_out}, {16'd0, m_cnt});
    if (m_valid) begin
      check_val("opcode", {25'd0, opcode_out}, {25'd0, m_op});
      check_val("funct3", {29'd0, funct3_out}, {29'd0, m_f3});
      check_val("funct7", {25'd0, funct7_out}, {25'd0, m_f7});
      check_val("rd", {27'd0, rd_out}, {27'd0, m_rd});
      check_val("rs1", rs1_value_out, m_rs1);
      check_val("mux", mux_result_out, m_mux);
      check_val("illegal", {31'd0, illegal_out}, {31'd0, m_ill});
    end
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    instr_valid_in = 1'b0; alu_ready_in = 1'b0; wb_en_in = 1'b0;
    model_reset();
    @(negedge clk_in);
    check_val("rst_valid", {31'd0, dec_valid_out}, 32'd0);
    check_val("rst_ready", {31'd0, instr_ready_out}, 32'd0);
    check_val("rst_count", {16'd0, issue_count_out}, 32'd0);
    check_val("rst_ill", {31'd0, illegal_out}, 32'd0);
    check_val("rst_fields", {opcode_out, funct3_out, funct7_out, rd_out, 10'd0}, 32'd0);
    check_val("rst_ops", rs1_value_out | mux_result_out, 32'd0);
    rst_in = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  f7;
    int sel;
    w   = $urandom;
    sel = int'($urandom_range(0, 9));
    if (sel < 4)      w[6:0] = 7'h33;
    else if (sel < 8) w[6:0] = 7'h13;
    sel = int'($urandom_range(0, 3));
    f7  = (sel == 0) ? 7'h00 : (sel == 1) ? 7'h20 : w[31:25];
    if (sel < 3) w[31:25] = f7;
    return w;
  endfunction

  logic [15:0] saved_cnt;
  logic [31:0] saved_rs1;

  initial begin
    rst_in = 1'b1;
    instr_valid_in = 1'b0; instr_in = 32'd0; alu_ready_in = 1'b0;
    wb_en_in = 1'b0; wb_rd_in = 5'd0; wb_data_in = 32'd0;
    model_reset();
    do_reset();

    // add x3,x1,x2 with x1=5, x2=3
    cycle(1'b0, 32'd0, 1'b1, 1'b1, 5'd1, 32'd5);
    cycle(1'b0, 32'd0, 1'b1, 1'b1, 5'd2, 32'd3);
    cycle(1'b1, 32'h002081B3, 1'b1, 1'b0, 5'd0, 32'd0);
    check_val("add_op", {25'd0, opcode_out}, 32'h33);
    check_val("add_rs1", rs1_value_out, 32'd5);
    check_val("add_mux", mux_result_out, 32'd3);
    check_val("add_rd", {27'd0, rd_out}, 32'd3);

    // srai / addi immediates
    cycle(1'b0, 32'd0, 1'b1, 1'b1, 5'd1, 32'h80000000);
    cycle(1'b1, 32'h4040D093, 1'b1, 1'b0, 5'd0, 32'd0);
    check_val("srai_f7", {25'd0, funct7_out}, 32'h20);
    check_val("srai_mux", mux_result_out, 32'h00000404);
    check_val("srai_ill", {31'd0, illegal_out}, 32'd0);
    cycle(1'b1, 32'hFFF08093, 1'b1, 1'b0, 5'd0, 32'd0);
    check_val("addi_mux", mux_result_out, 32'hFFFFFFFF);
    check_val("addi_f7", {25'd0, funct7_out}, 32'd0);

    // stall for 3 cycles then consume and accept together
    saved_cnt = issue_count_out;
    saved_rs1 = rs1_value_out;
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h002081B3, 1'b0, 1'b1, 5'd1, 32'hABCD0000);
    check_val("stall_cnt", {16'd0, issue_count_out}, {16'd0, saved_cnt});
    check_val("stall_rs1", rs1_value_out, saved_rs1);
    cycle(1'b1, 32'h002081B3, 1'b1, 1'b0, 5'd0, 32'd0);
    check_val("nobubble_cnt", {16'd0, issue_count_out}, {16'd0, saved_cnt + 16'd1});
    check_val("nobubble_rs1", rs1_value_out, 32'hABCD0000);

    // bypass and x0
    cycle(1'b1, 32'h00008293, 1'b1, 1'b1, 5'd1, 32'h1234);
    check_val("bypass", rs1_value_out, 32'h1234);
    cycle(1'b0, 32'd0, 1'b1, 1'b1, 5'd0, 32'hFFFF);
    cycle(1'b1, 32'h00000293, 1'b1, 1'b0, 5'd0, 32'd0);
    check_val("x0_read", rs1_value_out, 32'd0);

    // illegal forms
    cycle(1'b1, 32'h00000003, 1'b1, 1'b0, 5'd0, 32'd0);
    check_val("load_ill", {31'd0, illegal_out}, 32'd1);
    check_val("load_ops", rs1_value_out | mux_result_out, 32'd0);
    cycle(1'b1, 32'h02000033, 1'b1, 1'b0, 5'd0, 32'd0);
    check_val("f7_ill", {31'd0, illegal_out}, 32'd1);

    // reset while stalled drops the beat without a clock edge
    cycle(1'b1, 32'h002081B3, 1'b0, 1'b0, 5'd0, 32'd0);
    #2;
    rst_in = 1'b1;
    #1;
    check_val("async_rst", {31'd0, dec_valid_out}, 32'd0);
    do_reset();

    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), rand_instr(), 1'($urandom_range(0, 2) != 0),
            1'($urandom), 5'($urandom), $urandom);
    end

    // counter wrap from a clean reset
    do_reset();
    for (int i = 0; i < 65536; i++) begin
      cycle(1'b1, rand_instr(), 1'b1, 1'($urandom), 5'($urandom), $urandom);
    end
    check_val("wrap", {16'd0, issue_count_out}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
